mem_stage_lsx: RTL



---
 rtl/mem_stage_lsx.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_stage_lsx.sv
// MEM pipeline stage: completes EX-issued loads/stores, buffers the response across WB stalls,
// extracts sub-word load data and drops responses that belong to flushed instructions.
module mem_stage_lsx #(
   parameter int unsigned PC_W     = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned LOAD_EXT = 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     es_to_ms_valid,
   output logic                     ms_allow_in,
   input  logic [PC_W+REG_AW+38:0]  es_to_ms_bus,
   input  logic                     ws_allow_in,
   output logic                     ms_to_ws_valid,
   output logic [PC_W+REG_AW+32:0]  ms_to_ws_bus,
   output logic [REG_AW+33:0]       ms_to_ds_bus,
   input  logic                     ms_flush,
   input  logic                     data_sram_data_ok,
   input  logic [31:0]              data_sram_rdata
);

   localparam int unsigned ES_W = PC_W + REG_AW + 39;

   logic              ms_valid_q;
   logic [ES_W-1:0]   es_q;
   logic              data_got_q;
   logic [31:0]       data_buf_q;
   logic              discard_q;

   logic [PC_W-1:0]   pc;
   logic              gr_we;
   logic              res_from_mem;
   logic              mem_req;
   logic [2:0]        mem_op;
   logic [REG_AW-1:0] dest;
   logic [31:0]       alu_result;
   logic              unused_es_msb;

   // Fields are packed from the LSB up; the top bit of the EX bus is reserved.
   assign pc            = es_q[PC_W-1:0];
   assign gr_we         = es_q[PC_W];
   assign res_from_mem  = es_q[PC_W+1];
   assign mem_req       = es_q[PC_W+2];
   assign mem_op        = es_q[PC_W+5:PC_W+3];
   assign dest          = es_q[PC_W+6 +: REG_AW];
   assign alu_result    = es_q[PC_W+REG_AW+6 +: 32];
   assign unused_es_msb = es_q[ES_W-1];

   logic        ms_ready_go;
   logic        accept;
   logic        leave;
   logic [31:0] word;
   logic [1:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] final_result;
   logic        fwd_valid;
   logic        load_pending;

   assign ms_ready_go    = !mem_req || data_got_q || (data_sram_data_ok && !discard_q);
   assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ws_allow_in);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !ms_flush;
   assign accept         = es_to_ms_valid && ms_allow_in && !ms_flush;
   assign leave          = ms_valid_q && ms_ready_go && ws_allow_in;

   assign word     = data_got_q ? data_buf_q : data_sram_rdata;
   assign off      = alu_result[1:0];
   assign byte_sel = word[{off, 3'b000} +: 8];
   assign half_sel = off[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_data = word;
      if (LOAD_EXT != 0) begin
         unique case (mem_op)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = word;
         endcase
      end
   end

   assign final_result = res_from_mem ? load_data : alu_result;
   assign fwd_valid    = ms_valid_q && gr_we && (dest != '0);
   assign load_pending = fwd_valid && res_from_mem && !ms_ready_go;

   assign ms_to_ws_bus = {final_result, dest, gr_we, pc};
   assign ms_to_ds_bus = {fwd_valid, load_pending, dest, final_result};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid_q <= 1'b0;
         es_q       <= '0;
         data_got_q <= 1'b0;
         data_buf_q <= '0;
         discard_q  <= 1'b0;
      end else begin
         if (ms_flush) begin
            ms_valid_q <= 1'b0;
         end else if (ms_allow_in) begin
            ms_valid_q <= es_to_ms_valid;
         end

         if (accept) begin
            es_q <= es_to_ms_bus;
         end

         if (accept) begin
            data_got_q <= 1'b0;
            data_buf_q <= '0;
         end else if (ms_flush) begin
            data_got_q <= 1'b0;
         end else if (data_sram_data_ok && ms_valid_q && mem_req && !data_got_q && !discard_q
                      && !leave) begin
            data_got_q <= 1'b1;
            data_buf_q <= data_sram_rdata;
         end

         // A killed instruction still owns one in-flight response; swallow it when it shows up.
         if (discard_q && data_sram_data_ok) begin
            discard_q <= 1'b0;
         end else if (ms_flush && ms_valid_q && mem_req && !data_got_q && !data_sram_data_ok) begin
            discard_q <= 1'b1;
         end
      end
   end

endmodule
